// File: rtl/copy_desc_queue.sv
// copy_desc_queue: descriptor FIFO feeding a single-outstanding copy engine with completion and timeout tracking
module copy_desc_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [31:0]            desc_src,
  input  logic [31:0]            desc_dst,
  input  logic [15:0]            desc_len,
  output logic                   eng_start,
  output logic [31:0]            eng_src,
  output logic [31:0]            eng_dst,
  output logic [15:0]            eng_len,
  input  logic                   eng_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            done_cnt,
  output logic                   irq,
  output logic                   err,
  input  logic                   err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        state_q, state_d;
  logic [31:0]   src_mem [DEPTH];
  logic [31:0]   dst_mem [DEPTH];
  logic [15:0]   len_mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   src_q, dst_q;
  logic [15:0]   len_q, cnt_q;
  logic          eng_done_q, irq_q, err_q;
  logic          push, pop, done_edge, complete, timeout;

  // a full FIFO refuses pushes even while it is being popped
  assign desc_ready = level_q != (AW+1)'(DEPTH);
  assign push       = desc_valid && desc_ready;
  assign done_edge  = eng_done && !eng_done_q;
  assign eng_start  = state_q == ISSUE;
  assign busy       = state_q != IDLE;
  assign eng_src    = src_q;
  assign eng_dst    = dst_q;
  assign eng_len    = len_q;
  assign level      = level_q;
  assign done_cnt   = cnt_q;
  assign irq        = irq_q;
  assign err        = err_q;

  // descriptor storage; entries are only read while level marks them valid
  always_ff @(posedge clk)
    if (push) begin
      src_mem[wr_q] <= desc_src;
      dst_mem[wr_q] <= desc_dst;
      len_mem[wr_q] <= desc_len;
    end

  // sequencing: pop in IDLE, pulse start in ISSUE, watch for done edge or timeout in WAIT
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    pop      = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: if (level_q != '0) begin
        pop = 1'b1;
        if (len_mem[rd_q] != '0) state_d = ISSUE;
        else complete = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        tcnt_d  = '0;
      end
      WAIT: if (done_edge) begin
        complete = 1'b1;
        state_d  = IDLE;
      end else if (tcnt_q == TLIM) begin
        timeout = 1'b1;
        state_d = IDLE;
      end else tcnt_d = tcnt_q + TW'(1);
      default: state_d = IDLE;
    endcase
  end

  // state, FIFO pointers, engine operand latch and completion/error bookkeeping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      eng_done_q <= 1'b0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      wr_q       <= wr_q + AW'(push);
      rd_q       <= rd_q + AW'(pop);
      level_q    <= level_q + (AW+1)'(push) - (AW+1)'(pop);
      eng_done_q <= eng_done;
      irq_q      <= complete;
      cnt_q      <= cnt_q + 16'(complete);
      err_q      <= timeout || (err_q && !err_clr);
      if (pop) begin
        src_q <= src_mem[rd_q];
        dst_q <= dst_mem[rd_q];
        len_q <= len_mem[rd_q];
      end
    end
endmodule

// File: tb/tb_copy_desc_queue.sv
// tb_copy_desc_queue: directed and random checks of the descriptor queue against a transaction-level model
`timescale 1ns/1ps
module tb_copy_desc_queue;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  typedef struct packed {logic [31:0] s; logic [31:0] d; logic [15:0] l;} desc_t;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        desc_valid = 1'b0, err_clr = 1'b0, eng_done;
  logic [31:0] desc_src = '0, desc_dst = '0;
  logic [15:0] desc_len = '0;
  logic        desc_ready, eng_start, busy, irq, err;
  logic [31:0] eng_src, eng_dst;
  logic [15:0] eng_len, done_cnt;
  logic [2:0]  level;
  int nvec = 0, nfail = 0;
  int eng_mode = 0, eng_lat = 4, force_req = 0;
  int starts = 0, irqs = 0, npush = 0;
  desc_t expq[$];
  desc_t cur = '0;

  copy_desc_queue #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .eng_start(eng_start), .eng_src(eng_src), .eng_dst(eng_dst), .eng_len(eng_len),
    .eng_done(eng_done), .busy(busy), .level(level), .done_cnt(done_cnt),
    .irq(irq), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, output int n);
    logic acc = 1'b0;
    desc_valid = 1'b1; desc_src = s; desc_dst = d; desc_len = l; n = 0;
    while (!acc && n < 200) begin
      acc = desc_ready;
      tick();
      n++;
    end
    desc_valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_cnt(input logic [15:0] t, input int budget);
    int n = 0;
    while (done_cnt != t && n < budget) begin
      tick();
      n++;
    end
    chk("wait_done_cnt", done_cnt, t);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_level"}, level, 0);
    chk({t, "_ready"}, desc_ready, 1);
    chk({t, "_start"}, eng_start, 0);
    chk({t, "_src"}, eng_src, 0);
    chk({t, "_dst"}, eng_dst, 0);
    chk({t, "_len"}, eng_len, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_cnt"}, done_cnt, 0);
    chk({t, "_irq"}, irq, 0);
    chk({t, "_err"}, err, 0);
  endtask

  task automatic do_reset(input string t);
    #2 rst_n = 1'b0;
    #1 chk_reset(t);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // engine model: pulse done eng_lat cycles after a start, never respond, or hold done high
  initial begin
    int wcnt = 0, seen = 0;
    logic pend = 1'b0;
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = (eng_mode == 2);
      if (force_req != seen) begin
        eng_done = 1'b1;
        seen = force_req;
      end
      if (!rst_n || eng_mode != 0) pend = 1'b0;
      else if (pend) begin
        wcnt--;
        if (wcnt == 0) begin
          eng_done = 1'b1;
          pend = 1'b0;
        end
      end else if (eng_start) begin
        pend = 1'b1;
        wcnt = eng_lat;
      end
    end
  end

  // scoreboard: accepted descriptors must start in order (zero lengths skipped) and stay stable while busy
  always @(negedge clk) begin
    if (!rst_n) expq.delete();
    else begin
      if (eng_start) begin
        starts++;
        while (expq.size() > 0 && expq[0].l == 16'd0) void'(expq.pop_front());
        chk("start_has_desc", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          cur = expq.pop_front();
          chk("start_src", eng_src, cur.s);
          chk("start_dst", eng_dst, cur.d);
          chk("start_len", eng_len, cur.l);
        end
      end else if (busy) begin
        chk("hold_src", eng_src, cur.s);
        chk("hold_len", eng_len, cur.l);
      end
      if (irq) irqs++;
      if (desc_valid && desc_ready) begin
        expq.push_back({desc_src, desc_dst, desc_len});
        npush++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n, i0, s0, p0, nz;
    logic [15:0] d0, dd;
    do_reset("rst0");
    // single descriptor, engine answers after a fixed latency
    eng_lat = 12; i0 = irqs; s0 = starts;
    push(32'h1000, 32'h2000, 16'd8, n);
    chk("t1_first_push_edge", n, 1);
    tick();
    chk("t1_start", eng_start, 1);
    chk("t1_src", eng_src, 32'h1000);
    chk("t1_level", level, 0);
    tick();
    chk("t1_start_once", eng_start, 0);
    chk("t1_busy", busy, 1);
    wait_cnt(16'd1, 60);
    tick(); tick();
    chk("t1_starts", starts - s0, 1);
    chk("t1_irqs", irqs - i0, 1);
    chk("t1_idle", busy, 0);
    chk("t1_len_held", eng_len, 8);
    // fill the FIFO behind a busy engine
    eng_lat = 10; d0 = done_cnt; s0 = starts;
    for (int k = 0; k < 5; k++) push(32'h100 * k + 32'h10, 32'h900 + k, 16'(k + 1), n);
    chk("t2_level_full", level, 4);
    chk("t2_ready_low", desc_ready, 0);
    chk("t2_busy", busy, 1);
    push(32'hA000, 32'hB000, 16'd7, n);
    chk("t2_sixth_after_pop", done_cnt, d0 + 16'd1);
    wait_cnt(d0 + 16'd6, 200);
    tick(); tick();
    chk("t2_starts", starts - s0, 6);
    chk("t2_level_end", level, 0);
    // zero-length descriptor followed by a real one
    d0 = done_cnt; s0 = starts; i0 = irqs;
    push(32'h3000, 32'h4000, 16'd0, n);
    push(32'h5000, 32'h6000, 16'd3, n);
    chk("t3_zero_irq", irq, 1);
    chk("t3_zero_cnt", done_cnt, d0 + 16'd1);
    chk("t3_level_pushpop", level, 1);
    chk("t3_no_start", starts - s0, 0);
    chk("t3_idle", busy, 0);
    tick();
    chk("t3_start", eng_start, 1);
    chk("t3_len", eng_len, 3);
    wait_cnt(d0 + 16'd2, 60);
    tick(); tick();
    chk("t3_starts", starts - s0, 1);
    chk("t3_irqs", irqs - i0, 2);
    // done held high after the first completion: second descriptor must time out
    eng_lat = 5; d0 = done_cnt; i0 = irqs;
    push(32'hC000, 32'hD000, 16'd2, n);
    push(32'hC100, 32'hD100, 16'd2, n);
    wait_cnt(d0 + 16'd1, 60);
    eng_mode = 2;
    n = 0;
    while (!err && n < 60) begin
      tick();
      n++;
    end
    chk("t4_err", err, 1);
    chk("t4_cnt", done_cnt, d0 + 16'd1);
    chk("t4_idle", busy, 0);
    chk("t4_level", level, 0);
    tick();
    chk("t4_irqs", irqs - i0, 1);
    eng_mode = 0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", err, 0);
    // silent engine: exact timeout cycle, set beats clear
    eng_mode = 1; d0 = done_cnt;
    push(32'h7000, 32'h8000, 16'd5, n);
    tick();
    chk("t5_start", eng_start, 1);
    repeat (TMO) tick();
    chk("t5_no_err_yet", err, 0);
    chk("t5_wait", busy, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_set_wins", err, 1);
    chk("t5_idle", busy, 0);
    chk("t5_cnt", done_cnt, d0);
    tick();
    chk("t5_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t5_err_clr", err, 0);
    // reset while waiting with a backlog
    for (int k = 0; k < 3; k++) push(32'hE000 + k, 32'hF000 + k, 16'd4, n);
    tick(); tick();
    chk("t6_busy", busy, 1);
    chk("t6_level", level, 2);
    i0 = irqs;
    do_reset("t6");
    force_req++;
    repeat (3) tick();
    chk("t6_no_irq", irqs - i0, 0);
    chk("t6_cnt", done_cnt, 0);
    chk("t6_idle", busy, 0);
    chk("t6_level_after", level, 0);
    // random traffic against the scoreboard
    eng_mode = 0; p0 = npush; d0 = done_cnt; i0 = irqs;
    for (int c = 0; c < 400; c++) begin
      desc_valid = ($urandom_range(0, 1) == 1);
      desc_src   = $urandom;
      desc_dst   = $urandom;
      desc_len   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
      eng_lat    = $urandom_range(1, 8);
      tick();
    end
    desc_valid = 1'b0;
    n = 0;
    while ((level != 0 || busy) && n < 400) begin
      tick();
      n++;
    end
    tick(); tick();
    chk("rnd_drain", level == 0 && !busy, 1);
    dd = done_cnt - d0;
    chk("rnd_done_cnt", dd, npush - p0);
    chk("rnd_irqs", irqs - i0, npush - p0);
    chk("rnd_err", err, 0);
    nz = 0;
    foreach (expq[k]) if (expq[k].l != 16'd0) nz++;
    chk("rnd_unstarted", nz, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
